// File: rtl/id_decode_stage_pkg.sv
// Shared types and encodings for the ID stage: ALU codes, MIPS opcode/funct
// values and the packed control bundle handed to EX.
package id_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef struct packed {
    logic [3:0] alu_ctrl;
    logic       alusrc;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       is_shift;
    logic       imm_zext;
    logic       wb_pc4;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // An undefined encoding carries only the illegal flag so nothing downstream writes state.
  function automatic ctrl_t ctrl_illegal();
    ctrl_t c;
    c         = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/id_decode_stage_if.sv
// Fetch-to-ID valid/ready handshake carrying the instruction word and its PC.
interface id_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            if_valid;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic            id_ready;

  modport master (output if_valid, output if_instr, output if_pc, input id_ready);
  modport slave  (input if_valid, input if_instr, input if_pc, output id_ready);
endinterface

// File: rtl/id_decode_stage_decoder.sv
// Combinational MIPS decoder: instruction word to control bundle, resolved
// destination register and source-usage flags for hazard detection.
module id_decoder
  import id_pkg::*;
#(
  parameter bit EN_EXT = 1'b1
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic [4:0]  wreg,
  output logic        rs_used,
  output logic        rt_used
);

  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [4:0] rt_s;
  logic [4:0] rd_s;
  logic [4:0] wsel_s;
  ctrl_t      ctrl_s;
  logic       rs_used_s;
  logic       rt_used_s;

  assign op_s    = instr[31:26];
  assign funct_s = instr[5:0];
  assign rt_s    = instr[20:16];
  assign rd_s    = instr[15:11];

  // Main decode; an all-zero word is a true NOP rather than sll $0,$0,0.
  always_comb begin
    ctrl_s    = '0;
    wsel_s    = 5'd0;
    rs_used_s = 1'b0;
    rt_used_s = 1'b0;
    if (instr == 32'd0) begin
      ctrl_s = '0;
    end else begin
      case (op_s)
        OP_RTYPE: begin
          rs_used_s       = 1'b1;
          rt_used_s       = 1'b1;
          wsel_s          = rd_s;
          ctrl_s.regwrite = 1'b1;
          case (funct_s)
            FN_ADD: ctrl_s.alu_ctrl = ALU_ADD;
            FN_SUB: ctrl_s.alu_ctrl = ALU_SUB;
            FN_AND: ctrl_s.alu_ctrl = ALU_AND;
            FN_OR:  ctrl_s.alu_ctrl = ALU_OR;
            FN_XOR: ctrl_s.alu_ctrl = ALU_XOR;
            FN_SLT: ctrl_s.alu_ctrl = ALU_SLT;
            FN_SLL: begin ctrl_s.alu_ctrl = ALU_SLL; ctrl_s.is_shift = 1'b1; rs_used_s = 1'b0; end
            FN_SRL: begin ctrl_s.alu_ctrl = ALU_SRL; ctrl_s.is_shift = 1'b1; rs_used_s = 1'b0; end
            FN_SRA: begin ctrl_s.alu_ctrl = ALU_SRA; ctrl_s.is_shift = 1'b1; rs_used_s = 1'b0; end
            FN_JR:  begin ctrl_s.jr = 1'b1; ctrl_s.regwrite = 1'b0; end
            default: begin
              ctrl_s    = ctrl_illegal();
              rs_used_s = 1'b0;
              rt_used_s = 1'b0;
            end
          endcase
        end
        OP_ADDI: begin
          ctrl_s.alu_ctrl = ALU_ADD; ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
          wsel_s = rt_s; rs_used_s = 1'b1;
        end
        OP_ORI: begin
          ctrl_s.alu_ctrl = ALU_OR; ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
          ctrl_s.imm_zext = 1'b1; wsel_s = rt_s; rs_used_s = 1'b1;
        end
        OP_XORI: begin
          ctrl_s.alu_ctrl = ALU_XOR; ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
          ctrl_s.imm_zext = 1'b1; wsel_s = rt_s; rs_used_s = 1'b1;
        end
        OP_LUI: begin
          ctrl_s.alu_ctrl = ALU_LUI; ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
          wsel_s = rt_s;
        end
        OP_LW: begin
          ctrl_s.alu_ctrl = ALU_ADD; ctrl_s.alusrc = 1'b1; ctrl_s.regwrite = 1'b1;
          ctrl_s.memread = 1'b1; ctrl_s.memtoreg = 1'b1; wsel_s = rt_s; rs_used_s = 1'b1;
        end
        OP_SW: begin
          ctrl_s.alu_ctrl = ALU_ADD; ctrl_s.alusrc = 1'b1; ctrl_s.memwrite = 1'b1;
          rs_used_s = 1'b1; rt_used_s = 1'b1;
        end
        OP_BEQ: begin
          ctrl_s.alu_ctrl = ALU_SUB; ctrl_s.branch = 1'b1;
          rs_used_s = 1'b1; rt_used_s = 1'b1;
        end
        OP_BNE: begin
          ctrl_s.alu_ctrl = ALU_SUB; ctrl_s.branch = 1'b1; ctrl_s.branch_ne = 1'b1;
          rs_used_s = 1'b1; rt_used_s = 1'b1;
        end
        OP_J: ctrl_s.jump = 1'b1;
        OP_JAL: begin
          ctrl_s.jump = 1'b1; ctrl_s.jal = 1'b1; ctrl_s.regwrite = 1'b1;
          ctrl_s.wb_pc4 = 1'b1; wsel_s = 5'd31;
        end
        OP_ANDI, OP_SLTI, OP_ADDIU: begin
          if (EN_EXT) begin
            ctrl_s.alusrc   = 1'b1;
            ctrl_s.regwrite = 1'b1;
            wsel_s          = rt_s;
            rs_used_s       = 1'b1;
            case (op_s)
              OP_ANDI:  begin ctrl_s.alu_ctrl = ALU_AND; ctrl_s.imm_zext = 1'b1; end
              OP_SLTI:  ctrl_s.alu_ctrl = ALU_SLT;
              default:  ctrl_s.alu_ctrl = ALU_ADD;
            endcase
          end else begin
            ctrl_s = ctrl_illegal();
          end
        end
        default: ctrl_s = ctrl_illegal();
      endcase
    end
  end

  assign ctrl    = ctrl_s;
  assign wreg    = ctrl_s.regwrite ? wsel_s : 5'd0;
  assign rs_used = rs_used_s;
  assign rt_used = rt_used_s;

endmodule

// File: rtl/id_decode_stage.sv
// Registered ID stage: IF/ID holding register, decoder, ID/EX register, with
// load-use interlock (configurable bubbles), EX flush and global hold.
module id_decode_stage
  import id_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1,
  parameter bit EN_EXT           = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  id_decode_stage_if.slave    fe,
  input  logic                flush,
  input  logic                hold,
  output logic                ex_valid,
  output ctrl_t               ex_ctrl,
  output logic [XLEN-1:0]     ex_pc,
  output logic [4:0]          ex_rs,
  output logic [4:0]          ex_rt,
  output logic [4:0]          ex_wreg,
  output logic [XLEN-1:0]     ex_imm,
  output logic [4:0]          ex_shamt,
  output logic                illegal
);

  logic            s1_valid_r;
  logic [31:0]     s1_instr_r;
  logic [XLEN-1:0] s1_pc_r;

  logic            ex_valid_r;
  ctrl_t           ex_ctrl_r;
  logic [XLEN-1:0] ex_pc_r;
  logic [4:0]      ex_rs_r;
  logic [4:0]      ex_rt_r;
  logic [4:0]      ex_wreg_r;
  logic [XLEN-1:0] ex_imm_r;
  logic [4:0]      ex_shamt_r;
  logic            illegal_r;
  logic [1:0]      cnt_r;

  ctrl_t           dec_ctrl_s;
  logic [4:0]      dec_wreg_s;
  logic            rs_used_s;
  logic            rt_used_s;
  logic [XLEN-1:0] imm_ext_s;
  logic            hz_s;
  logic            stall_s;

  id_decoder #(.EN_EXT(EN_EXT)) u_dec (
    .instr   (s1_instr_r),
    .ctrl    (dec_ctrl_s),
    .wreg    (dec_wreg_s),
    .rs_used (rs_used_s),
    .rt_used (rt_used_s)
  );

  // Immediate extension selected by the decoded zero-extend flag.
  always_comb begin
    if (dec_ctrl_s.imm_zext) begin
      imm_ext_s = {{(XLEN-16){1'b0}}, s1_instr_r[15:0]};
    end else begin
      imm_ext_s = {{(XLEN-16){s1_instr_r[15]}}, s1_instr_r[15:0]};
    end
  end

  // A load in EX whose nonzero destination feeds a source used by the ID instruction.
  assign hz_s = s1_valid_r & ex_valid_r & ex_ctrl_r.memread & (ex_wreg_r != 5'd0) &
                (((ex_wreg_r == s1_instr_r[25:21]) & rs_used_s) |
                 ((ex_wreg_r == s1_instr_r[20:16]) & rt_used_s));
  assign stall_s     = hz_s | (cnt_r != 2'd0);
  assign fe.id_ready = ~flush & ~hold & ~stall_s;

  // Pipeline registers with priority flush > hold > stall > advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_instr_r <= 32'd0;
      s1_pc_r    <= {XLEN{1'b0}};
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= '0;
      ex_pc_r    <= {XLEN{1'b0}};
      ex_rs_r    <= 5'd0;
      ex_rt_r    <= 5'd0;
      ex_wreg_r  <= 5'd0;
      ex_imm_r   <= {XLEN{1'b0}};
      ex_shamt_r <= 5'd0;
      illegal_r  <= 1'b0;
      cnt_r      <= 2'd0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= '0;
      ex_wreg_r  <= 5'd0;
      illegal_r  <= 1'b0;
      cnt_r      <= 2'd0;
    end else if (hold) begin
      illegal_r <= 1'b0;
    end else if (stall_s) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= '0;
      ex_wreg_r  <= 5'd0;
      illegal_r  <= 1'b0;
      cnt_r      <= hz_s ? 2'(LOAD_USE_BUBBLES - 1) : cnt_r - 2'd1;
    end else begin
      ex_valid_r <= s1_valid_r;
      ex_ctrl_r  <= s1_valid_r ? dec_ctrl_s : '0;
      ex_pc_r    <= s1_pc_r;
      ex_rs_r    <= s1_instr_r[25:21];
      ex_rt_r    <= s1_instr_r[20:16];
      ex_wreg_r  <= s1_valid_r ? dec_wreg_s : 5'd0;
      ex_imm_r   <= imm_ext_s;
      ex_shamt_r <= s1_instr_r[10:6];
      illegal_r  <= s1_valid_r & dec_ctrl_s.illegal;
      s1_valid_r <= fe.if_valid;
      s1_instr_r <= fe.if_instr;
      s1_pc_r    <= fe.if_pc;
    end
  end

  assign ex_valid = ex_valid_r;
  assign ex_ctrl  = ex_ctrl_r;
  assign ex_pc    = ex_pc_r;
  assign ex_rs    = ex_rs_r;
  assign ex_rt    = ex_rt_r;
  assign ex_wreg  = ex_wreg_r;
  assign ex_imm   = ex_imm_r;
  assign ex_shamt = ex_shamt_r;
  assign illegal  = illegal_r;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench: two instances (1 bubble + ext set, 2 bubbles + no ext)
// driven by the same fetch stream and checked against hand-computed values.
module tb_id_decode_stage;
  import id_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        hold;

  id_decode_stage_if #(.XLEN(32)) fe1 ();
  id_decode_stage_if #(.XLEN(32)) fe2 ();

  assign fe1.if_valid = if_valid;
  assign fe1.if_instr = if_instr;
  assign fe1.if_pc    = if_pc;
  assign fe2.if_valid = if_valid;
  assign fe2.if_instr = if_instr;
  assign fe2.if_pc    = if_pc;

  logic        d1_ex_valid, d2_ex_valid, d1_illegal, d2_illegal;
  ctrl_t       d1_ex_ctrl, d2_ex_ctrl;
  logic [31:0] d1_ex_pc, d2_ex_pc, d1_ex_imm, d2_ex_imm;
  logic [4:0]  d1_ex_rs, d2_ex_rs, d1_ex_rt, d2_ex_rt;
  logic [4:0]  d1_ex_wreg, d2_ex_wreg, d1_ex_shamt, d2_ex_shamt;

  id_decode_stage #(.XLEN(32), .LOAD_USE_BUBBLES(1), .EN_EXT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .fe(fe1), .flush(flush), .hold(hold),
    .ex_valid(d1_ex_valid), .ex_ctrl(d1_ex_ctrl), .ex_pc(d1_ex_pc),
    .ex_rs(d1_ex_rs), .ex_rt(d1_ex_rt), .ex_wreg(d1_ex_wreg),
    .ex_imm(d1_ex_imm), .ex_shamt(d1_ex_shamt), .illegal(d1_illegal)
  );

  id_decode_stage #(.XLEN(32), .LOAD_USE_BUBBLES(2), .EN_EXT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .fe(fe2), .flush(flush), .hold(hold),
    .ex_valid(d2_ex_valid), .ex_ctrl(d2_ex_ctrl), .ex_pc(d2_ex_pc),
    .ex_rs(d2_ex_rs), .ex_rt(d2_ex_rt), .ex_wreg(d2_ex_wreg),
    .ex_imm(d2_ex_imm), .ex_shamt(d2_ex_shamt), .illegal(d2_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  ctrl_t c_lw, c_add, c_andi, c_ill, c_jal, c_addi;
  logic [31:0] i_lw, i_add, i_lw0, i_add0, i_ori, i_andi, i_addi, i_jal, i_ori2;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    flush = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 32'd0, 32'd0);

    c_lw  = '0; c_lw.alu_ctrl = 4'b0010; c_lw.alusrc = 1'b1; c_lw.regwrite = 1'b1;
    c_lw.memread = 1'b1; c_lw.memtoreg = 1'b1;
    c_add = '0; c_add.alu_ctrl = 4'b0010; c_add.regwrite = 1'b1;
    c_andi = '0; c_andi.alu_ctrl = 4'b0000; c_andi.alusrc = 1'b1; c_andi.regwrite = 1'b1;
    c_andi.imm_zext = 1'b1;
    c_ill = '0; c_ill.illegal = 1'b1;
    c_jal = '0; c_jal.regwrite = 1'b1; c_jal.jump = 1'b1; c_jal.jal = 1'b1; c_jal.wb_pc4 = 1'b1;
    c_addi = '0; c_addi.alu_ctrl = 4'b0010; c_addi.alusrc = 1'b1; c_addi.regwrite = 1'b1;

    i_lw   = 32'h8D28_0000;                         // lw $8,0($9)
    i_add  = 32'h010B_5020;                         // add $10,$8,$11
    i_lw0  = enc_i(6'b100011, 5'd9, 5'd0, 16'd4);   // lw $0,4($9)
    i_add0 = enc_r(5'd0, 5'd0, 5'd10, 6'b100000);   // add $10,$0,$0
    i_ori  = enc_i(6'b001101, 5'd6, 5'd5, 16'h00F0);
    i_andi = enc_i(6'b001100, 5'd3, 5'd2, 16'h8001);
    i_addi = enc_i(6'b001000, 5'd0, 5'd4, 16'hFFF9);
    i_jal  = {6'b000011, 26'h000_0100};
    i_ori2 = enc_i(6'b001101, 5'd1, 5'd7, 16'h0001);

    // reset state
    tick();
    tick();
    chk("rst_ex_valid1", 32'(d1_ex_valid), 32'd0);
    chk("rst_ex_ctrl1", 32'(d1_ex_ctrl), 32'd0);
    chk("rst_ex_pc1", d1_ex_pc, 32'd0);
    chk("rst_illegal1", 32'(d1_illegal), 32'd0);
    chk("rst_ex_valid2", 32'(d2_ex_valid), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_id_ready1", 32'(fe1.id_ready), 32'd1);

    // load-use: 1 bubble on dut1, 2 bubbles on dut2
    drive(1'b1, i_lw, 32'h100);
    tick();
    drive(1'b1, i_add, 32'h104);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("lu_lw_valid1", 32'(d1_ex_valid), 32'd1);
    chk("lu_lw_ctrl1", 32'(d1_ex_ctrl), 32'(c_lw));
    chk("lu_lw_wreg1", 32'(d1_ex_wreg), 32'd8);
    chk("lu_lw_pc1", d1_ex_pc, 32'h100);
    chk("lu_rdy_low1", 32'(fe1.id_ready), 32'd0);
    chk("lu_rdy_low2", 32'(fe2.id_ready), 32'd0);
    tick();
    chk("lu_bub1_valid1", 32'(d1_ex_valid), 32'd0);
    chk("lu_bub1_valid2", 32'(d2_ex_valid), 32'd0);
    chk("lu_bub1_ctrl1", 32'(d1_ex_ctrl), 32'd0);
    chk("lu_rdy_back1", 32'(fe1.id_ready), 32'd1);
    chk("lu_rdy_still2", 32'(fe2.id_ready), 32'd0);
    tick();
    chk("lu_add_valid1", 32'(d1_ex_valid), 32'd1);
    chk("lu_add_ctrl1", 32'(d1_ex_ctrl), 32'(c_add));
    chk("lu_add_wreg1", 32'(d1_ex_wreg), 32'd10);
    chk("lu_bub2_valid2", 32'(d2_ex_valid), 32'd0);
    chk("lu_rdy_back2", 32'(fe2.id_ready), 32'd1);
    tick();
    chk("lu_add_valid2", 32'(d2_ex_valid), 32'd1);
    chk("lu_add_alu2", 32'(d2_ex_ctrl.alu_ctrl), 32'b0010);
    chk("lu_add_wreg2", 32'(d2_ex_wreg), 32'd10);
    chk("lu_add_pc2", d2_ex_pc, 32'h104);
    chk("lu_drain_valid1", 32'(d1_ex_valid), 32'd0);

    // load to $0 never interlocks
    drive(1'b1, i_lw0, 32'h200);
    tick();
    drive(1'b1, i_add0, 32'h204);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("z_lw_valid1", 32'(d1_ex_valid), 32'd1);
    chk("z_rdy1", 32'(fe1.id_ready), 32'd1);
    chk("z_rdy2", 32'(fe2.id_ready), 32'd1);
    tick();
    chk("z_add_valid1", 32'(d1_ex_valid), 32'd1);
    chk("z_add_pc1", d1_ex_pc, 32'h204);
    chk("z_add_valid2", 32'(d2_ex_valid), 32'd1);
    chk("z_add_wreg2", 32'(d2_ex_wreg), 32'd10);

    // flush in the cycle the hazard is seen
    drive(1'b1, i_lw, 32'h300);
    tick();
    drive(1'b1, i_add, 32'h304);
    tick();
    flush = 1'b1;
    drive(1'b1, i_ori, 32'h308);
    #1;
    chk("fl_rdy_low1", 32'(fe1.id_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("fl_ex_valid1", 32'(d1_ex_valid), 32'd0);
    chk("fl_ex_valid2", 32'(d2_ex_valid), 32'd0);
    chk("fl_rdy1", 32'(fe1.id_ready), 32'd1);
    chk("fl_rdy2", 32'(fe2.id_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("fl_s1_dead1", 32'(d1_ex_valid), 32'd0);
    tick();
    chk("fl_ori_valid1", 32'(d1_ex_valid), 32'd1);
    chk("fl_ori_pc1", d1_ex_pc, 32'h308);
    chk("fl_ori_imm1", d1_ex_imm, 32'h0000_00F0);
    chk("fl_ori_valid2", 32'(d2_ex_valid), 32'd1);
    chk("fl_ori_wreg2", 32'(d2_ex_wreg), 32'd5);

    // andi: legal with extended set, illegal without
    drive(1'b1, i_andi, 32'h400);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("an_ctrl1", 32'(d1_ex_ctrl), 32'(c_andi));
    chk("an_imm1", d1_ex_imm, 32'h0000_8001);
    chk("an_wreg1", 32'(d1_ex_wreg), 32'd2);
    chk("an_illegal1", 32'(d1_illegal), 32'd0);
    chk("an_illegal2", 32'(d2_illegal), 32'd1);
    chk("an_ctrl2", 32'(d2_ex_ctrl), 32'(c_ill));
    chk("an_wreg2", 32'(d2_ex_wreg), 32'd0);
    tick();
    chk("an_pulse_end2", 32'(d2_illegal), 32'd0);

    // instr 0 is a valid NOP with every control bit clear
    drive(1'b1, 32'd0, 32'h480);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    tick();
    chk("nop_valid1", 32'(d1_ex_valid), 32'd1);
    chk("nop_ctrl1", 32'(d1_ex_ctrl), 32'd0);
    chk("nop_illegal2", 32'(d2_illegal), 32'd0);

    // hold for three cycles with jal in ID
    drive(1'b1, i_addi, 32'h500);
    tick();
    drive(1'b1, i_jal, 32'h504);
    tick();
    hold = 1'b1;
    drive(1'b1, i_ori2, 32'h508);
    #1;
    chk("hd_rdy_low1", 32'(fe1.id_ready), 32'd0);
    chk("hd_addi_ctrl1", 32'(d1_ex_ctrl), 32'(c_addi));
    chk("hd_addi_imm1", d1_ex_imm, 32'hFFFF_FFF9);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hd_pc1", d1_ex_pc, 32'h500);
      chk("hd_wreg1", 32'(d1_ex_wreg), 32'd4);
      chk("hd_valid2", 32'(d2_ex_valid), 32'd1);
      chk("hd_pc2", d2_ex_pc, 32'h500);
    end
    hold = 1'b0;
    #1;
    chk("hd_rdy_back1", 32'(fe1.id_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("jal_ctrl1", 32'(d1_ex_ctrl), 32'(c_jal));
    chk("jal_wreg1", 32'(d1_ex_wreg), 32'd31);
    chk("jal_pc1", d1_ex_pc, 32'h504);
    chk("jal_wreg2", 32'(d2_ex_wreg), 32'd31);
    tick();
    chk("post_hold_pc1", d1_ex_pc, 32'h508);
    chk("post_hold_wreg1", 32'(d1_ex_wreg), 32'd7);

    // asynchronous reset in the middle of a stream
    drive(1'b1, i_addi, 32'h600);
    tick();
    drive(1'b1, i_addi, 32'h604);
    tick();
    chk("mr_pre_valid1", 32'(d1_ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_valid1", 32'(d1_ex_valid), 32'd0);
    chk("mr_ctrl1", 32'(d1_ex_ctrl), 32'd0);
    chk("mr_pc2", d2_ex_pc, 32'd0);
    drive(1'b1, i_add, 32'h700);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mr_rdy1", 32'(fe1.id_ready), 32'd1);
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("mr_e1_valid1", 32'(d1_ex_valid), 32'd0);
    tick();
    chk("mr_e2_valid1", 32'(d1_ex_valid), 32'd1);
    chk("mr_e2_pc1", d1_ex_pc, 32'h700);
    chk("mr_e2_wreg2", 32'(d2_ex_wreg), 32'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
